// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multicycle multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multdiv_pkg;

   localparam int WIDTH = 32;
   localparam int ITER  = 32;
   localparam int CNT_W = 6;

   localparam logic [WIDTH-1:0] INT_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

   // True when a 64-bit two's-complement value survives truncation to 32 bits.
   function automatic logic fitsInWord(input logic [2*WIDTH-1:0] value);
      return value[2*WIDTH-1:WIDTH] == {WIDTH{value[WIDTH-1]}};
   endfunction

endpackage

// File: rtl/signed_magnitude.sv
// Splits a two's-complement operand into absolute value and sign bit.
// Latency: combinational.
// Backpressure: none; pure function of the input.
module signed_magnitude #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] value,
   output logic [WIDTH-1:0] magnitude,
   output logic             sign
);

   // INT_MIN maps onto its own bit pattern, which read unsigned is 2^31.
   always_comb begin
      sign      = value[WIDTH-1];
      magnitude = sign ? -value : value;
   end

endmodule

// File: rtl/multdiv_unit.sv
// Signed 32-bit multiply/divide, one bit per cycle, feeding the register file write port.
// Latency: 33 rising edges from the start edge back to IDLE; result presented in DONE.
// Backpressure: none; starts outside IDLE are dropped, the core stalls on data_busy.
module multdiv_unit #(
   parameter int WIDTH = multdiv_pkg::WIDTH,
   parameter int ITER  = multdiv_pkg::ITER
) (
   input  logic             clock,
   input  logic             ctrl_reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic [4:0]       ctrl_destReg,
   output logic             data_busy,
   output logic             data_resultRDY,
   output logic             data_exception,
   output logic [WIDTH-1:0] data_writeReg,
   output logic [4:0]       ctrl_writeReg,
   output logic             ctrl_writeEnable
);
   import multdiv_pkg::*;

   state_t state;
   state_t nextState;

   logic [CNT_W-1:0]   iterCount;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] accNext;
   logic [WIDTH-1:0]   magAReg;
   logic [WIDTH-1:0]   magBReg;
   logic               signReg;
   logic               divByZero;
   logic               divOverflow;

   logic [WIDTH-1:0]   magA;
   logic [WIDTH-1:0]   magB;
   logic               signA;
   logic               signB;

   logic               startMult;
   logic               startDiv;
   logic               iterating;
   logic               lastIter;

   logic [WIDTH:0]     mulSum;
   logic [2*WIDTH-1:0] mulNext;
   logic [2*WIDTH-1:0] divShift;
   logic [WIDTH:0]     divDiff;
   logic [2*WIDTH-1:0] divNext;
   logic [2*WIDTH-1:0] prodSigned;
   logic [WIDTH-1:0]   quotMag;
   logic [WIDTH-1:0]   finalResult;
   logic               finalExc;

   signed_magnitude #(.WIDTH(WIDTH)) uMagA (
      .value     (data_operandA),
      .magnitude (magA),
      .sign      (signA)
   );

   signed_magnitude #(.WIDTH(WIDTH)) uMagB (
      .value     (data_operandB),
      .magnitude (magB),
      .sign      (signB)
   );

   // State register; reset aborts any operation in flight.
   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) state <= IDLE;
      else            state <= nextState;
   end

   // Next-state logic: MULT wins over DIV, DONE always lasts one cycle.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (ctrl_MULT)     nextState = MULT;
            else if (ctrl_DIV) nextState = DIV;
         end
         MULT, DIV: begin
            if (iterCount == CNT_W'(ITER - 1)) nextState = DONE;
         end
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Control decode driving the datapath and output registers.
   always_comb begin
      startMult = (state == IDLE) && ctrl_MULT;
      startDiv  = (state == IDLE) && !ctrl_MULT && ctrl_DIV;
      iterating = (state == MULT) || (state == DIV);
      lastIter  = iterating && (iterCount == CNT_W'(ITER - 1));
   end

   // One iteration step: shift-add for multiply, restoring subtract for divide.
   always_comb begin
      mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, magAReg} : '0);
      mulNext  = {mulSum, acc[WIDTH-1:1]};
      divShift = {acc[2*WIDTH-2:0], 1'b0};
      divDiff  = {1'b0, divShift[2*WIDTH-1:WIDTH]} - {1'b0, magBReg};
      divNext  = divDiff[WIDTH] ? divShift
                                : {divDiff[WIDTH-1:0], divShift[WIDTH-1:1], 1'b1};
      accNext  = (state == MULT) ? mulNext : divNext;
   end

   // Result and exception as they will stand once the last step lands.
   always_comb begin
      prodSigned = signReg ? -accNext : accNext;
      quotMag    = accNext[WIDTH-1:0];
      if (state == MULT) begin
         finalResult = prodSigned[WIDTH-1:0];
         finalExc    = !fitsInWord(prodSigned);
      end else begin
         // A zero divisor leaves an all-ones quotient, so it is overridden.
         finalResult = divByZero ? '0 : (signReg ? -quotMag : quotMag);
         finalExc    = divByZero || divOverflow;
      end
   end

   // Operand capture on the start edge, then one accumulator step per cycle.
   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         iterCount      <= '0;
         acc            <= '0;
         magAReg        <= '0;
         magBReg        <= '0;
         signReg        <= 1'b0;
         divByZero      <= 1'b0;
         divOverflow    <= 1'b0;
         ctrl_writeReg  <= '0;
         data_writeReg  <= '0;
         data_exception <= 1'b0;
      end else if (startMult || startDiv) begin
         iterCount      <= '0;
         // Multiply shifts the multiplier out of the low half; divide shifts the dividend up.
         acc            <= {{WIDTH{1'b0}}, (startMult ? magB : magA)};
         magAReg        <= magA;
         magBReg        <= magB;
         signReg        <= signA ^ signB;
         divByZero      <= (data_operandB == '0);
         divOverflow    <= (data_operandA == INT_MIN) && (data_operandB == '1);
         ctrl_writeReg  <= ctrl_destReg;
         data_writeReg  <= '0;
         data_exception <= 1'b0;
      end else if (iterating) begin
         iterCount <= iterCount + CNT_W'(1);
         acc       <= accNext;
         if (lastIter) begin
            data_writeReg  <= finalResult;
            data_exception <= finalExc;
         end
      end
   end

   // Handshake outputs registered from the next state so DONE sees them for its whole cycle.
   always_ff @(posedge clock or posedge ctrl_reset) begin
      if (ctrl_reset) begin
         data_busy        <= 1'b0;
         data_resultRDY   <= 1'b0;
         ctrl_writeEnable <= 1'b0;
      end else begin
         data_busy        <= (nextState != IDLE);
         data_resultRDY   <= (nextState == DONE);
         ctrl_writeEnable <= lastIter && !finalExc && (ctrl_writeReg != 5'd0);
      end
   end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed self-checking bench for multdiv_unit with hand-computed results.
// Latency: checks RDY at start+32 edges and IDLE at start+33.
// Backpressure: exercises ignored overlapping starts and back-to-back starts.
module tb_multdiv_unit;

   logic        clock = 1'b0;
   logic        ctrl_reset = 1'b1;
   logic        ctrl_MULT = 1'b0;
   logic        ctrl_DIV = 1'b0;
   logic [31:0] data_operandA = '0;
   logic [31:0] data_operandB = '0;
   logic [4:0]  ctrl_destReg = '0;
   logic        data_busy;
   logic        data_resultRDY;
   logic        data_exception;
   logic [31:0] data_writeReg;
   logic [4:0]  ctrl_writeReg;
   logic        ctrl_writeEnable;

   int checkCount = 0;
   int failCount  = 0;
   int edgeCnt    = 0;

   multdiv_unit dut (
      .clock            (clock),
      .ctrl_reset       (ctrl_reset),
      .ctrl_MULT        (ctrl_MULT),
      .ctrl_DIV         (ctrl_DIV),
      .data_operandA    (data_operandA),
      .data_operandB    (data_operandB),
      .ctrl_destReg     (ctrl_destReg),
      .data_busy        (data_busy),
      .data_resultRDY   (data_resultRDY),
      .data_exception   (data_exception),
      .data_writeReg    (data_writeReg),
      .ctrl_writeReg    (ctrl_writeReg),
      .ctrl_writeEnable (ctrl_writeEnable)
   );

   always #5 clock = ~clock;

   always @(posedge clock) edgeCnt <= edgeCnt + 1;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         failCount++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Drives a start request, lets it be sampled on the next rising edge, returns that edge index.
   task automatic startOp(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] dest, output int e0);
      ctrl_MULT     = m;
      ctrl_DIV      = d;
      data_operandA = a;
      data_operandB = b;
      ctrl_destReg  = dest;
      @(posedge clock);
      #1;
      e0        = edgeCnt;
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
   endtask

   // Waits (bounded) for data_resultRDY; returns its edge index or -1 on timeout.
   task automatic waitResult(output int rdyAt);
      rdyAt = -1;
      for (int i = 0; i < 45; i++) begin
         @(posedge clock);
         #1;
         if (data_resultRDY) begin
            rdyAt = edgeCnt;
            break;
         end
      end
   endtask

   task automatic countRdy(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
         if (data_resultRDY) cnt++;
      end
   endtask

   // Full operation: start, await DONE, check the write request, then check the IDLE return.
   task automatic runOp(input string tag, input logic m, input logic d, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] dest, input logic [31:0] expRes,
                        input logic expExc, input logic expWe);
      int e0;
      int rdyAt;
      startOp(m, d, a, b, dest, e0);
      waitResult(rdyAt);
      checkVal({tag, ".latency"}, 32'(rdyAt - e0), 32'd32);
      checkVal({tag, ".result"}, data_writeReg, expRes);
      checkVal({tag, ".exc"}, 32'(data_exception), 32'(expExc));
      checkVal({tag, ".we"}, 32'(ctrl_writeEnable), 32'(expWe));
      checkVal({tag, ".wreg"}, 32'(ctrl_writeReg), 32'(dest));
      @(posedge clock);
      #1;
      checkVal({tag, ".idle"}, {29'd0, data_busy, data_resultRDY, ctrl_writeEnable}, 32'd0);
   endtask

   initial begin
      int e0;
      int e1;
      int rdyAt;
      int cnt;

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      checkVal("reset.ctl", {26'd0, data_busy, data_resultRDY, data_exception, ctrl_writeEnable, 2'b00}, 32'd0);
      checkVal("reset.data", data_writeReg, 32'd0);
      checkVal("reset.wreg", 32'(ctrl_writeReg), 32'd0);
      @(negedge clock);
      ctrl_reset = 1'b0;
      @(posedge clock);
      #1;

      // MULT 7 x -6 -> -42, with busy checked through the operation
      startOp(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, 5'd5, e0);
      checkVal("mul1.busyStart", 32'(data_busy), 32'd1);
      waitResult(rdyAt);
      checkVal("mul1.latency", 32'(rdyAt - e0), 32'd32);
      checkVal("mul1.busyDone", 32'(data_busy), 32'd1);
      checkVal("mul1.result", data_writeReg, 32'hFFFF_FFD6);
      checkVal("mul1.we", 32'(ctrl_writeEnable), 32'd1);
      checkVal("mul1.wreg", 32'(ctrl_writeReg), 32'd5);
      checkVal("mul1.exc", 32'(data_exception), 32'd0);
      @(posedge clock);
      #1;
      checkVal("mul1.idle", {29'd0, data_busy, data_resultRDY, ctrl_writeEnable}, 32'd0);

      runOp("div1", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd3, 32'hFFFF_FFFD, 1'b0, 1'b1);
      runOp("div0", 1'b0, 1'b1, 32'd100, 32'd0, 5'd4, 32'd0, 1'b1, 1'b0);
      runOp("mulOvf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd6, 32'd0, 1'b1, 1'b0);
      runOp("divOvf", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000, 1'b1, 1'b0);
      runOp("mulMin", 1'b1, 1'b0, 32'h8000_0000, 32'd1, 5'd8, 32'h8000_0000, 1'b0, 1'b1);
      runOp("divNeg", 1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 5'd9, 32'hFFFF_FFF2, 1'b0, 1'b1);
      runOp("both", 1'b1, 1'b1, 32'd20, 32'd4, 5'd10, 32'd80, 1'b0, 1'b1);
      runOp("dest0", 1'b1, 1'b0, 32'd5, 32'd5, 5'd0, 32'd25, 1'b0, 1'b0);

      // Second MULT request at E10 is dropped; exactly one RDY appears
      startOp(1'b1, 1'b0, 32'd3, 32'd3, 5'd1, e0);
      repeat (9) @(posedge clock);
      #1;
      ctrl_MULT     = 1'b1;
      data_operandA = 32'd100;
      data_operandB = 32'd100;
      @(posedge clock);
      #1;
      ctrl_MULT = 1'b0;
      waitResult(rdyAt);
      checkVal("ovl.latency", 32'(rdyAt - e0), 32'd32);
      checkVal("ovl.result", data_writeReg, 32'd9);
      countRdy(40, cnt);
      checkVal("ovl.rdyCount", 32'(cnt), 32'd0);

      // Back-to-back: start driven at E33, sampled on the first IDLE edge, RDY at E66
      startOp(1'b1, 1'b0, 32'd12, 32'd11, 5'd2, e0);
      waitResult(rdyAt);
      checkVal("b2b.first", data_writeReg, 32'd132);
      @(posedge clock);
      #1;
      startOp(1'b0, 1'b1, 32'd144, 32'd12, 5'd2, e1);
      checkVal("b2b.accepted", 32'(data_busy), 32'd1);
      waitResult(rdyAt);
      checkVal("b2b.latency", 32'(rdyAt - e0), 32'd66);
      checkVal("b2b.result", data_writeReg, 32'd12);
      @(posedge clock);
      #1;

      // Reset at E15 of a DIV aborts it with no write request
      startOp(1'b0, 1'b1, 32'd1000, 32'd10, 5'd11, e0);
      repeat (15) @(posedge clock);
      #1;
      ctrl_reset = 1'b1;
      #1;
      checkVal("rst.ctl", {28'd0, data_busy, data_resultRDY, data_exception, ctrl_writeEnable}, 32'd0);
      checkVal("rst.data", data_writeReg, 32'd0);
      checkVal("rst.wreg", 32'(ctrl_writeReg), 32'd0);
      @(negedge clock);
      ctrl_reset = 1'b0;
      countRdy(40, cnt);
      checkVal("rst.noRdy", 32'(cnt), 32'd0);
      runOp("postRst", 1'b1, 1'b0, 32'd3, 32'd4, 5'd7, 32'd12, 1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
